// File: rtl/pll_lock_supervisor.sv
// Reset sequencer for an ECP5 EHXPLLL: pulses RST, waits for LOCK with bounded retries,
// qualifies lock over a stability window and releases a registered reset to the PLL domain.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int GLITCH_CYCLES = 4,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pll_locked,
    input  logic                 restart,
    output logic                 pll_rst,
    output logic                 sys_reset_n,
    output logic                 ready,
    output logic                 failed,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] retry_count,
    output logic [CNT_WIDTH-1:0] lost_count
);

    localparam int T_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int T_CD  = (STABLE_CYCLES > GLITCH_CYCLES) ? STABLE_CYCLES : GLITCH_CYCLES;
    localparam int T_MAX = (T_AB > T_CD) ? T_AB : T_CD;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0]        RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]        LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]        STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0]        GLITCH_LAST = TW'(GLITCH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] MAX_R       = CNT_WIDTH'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILISE = 3'd2,
        S_RUN       = 3'd3,
        S_FAILED    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    sync_q;
    logic          locked_s;
    logic          retry_inc, retry_clr, lost_inc;
    logic          pll_rst_d, sys_reset_n_d, ready_d, failed_d;

    // LOCK is asynchronous to the reference clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], pll_locked};
    end
    assign locked_s = sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_RESET_PLL;
            timer_q     <= '0;
            retry_count <= '0;
            lost_count  <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            failed      <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (retry_clr)      retry_count <= '0;
            else if (retry_inc) retry_count <= retry_count + 1'b1;
            if (lost_inc && (lost_count != '1)) lost_count <= lost_count + 1'b1;
            pll_rst     <= pll_rst_d;
            sys_reset_n <= sys_reset_n_d;
            ready       <= ready_d;
            failed      <= failed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        lost_inc  = 1'b0;
        if (restart) begin
            state_d   = S_RESET_PLL;
            retry_clr = 1'b1;
        end else begin
            case (state_q)
                S_RESET_PLL: if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = S_STABILISE;
                    end else if (timer_q == LOCK_LAST) begin
                        if (retry_count == MAX_R) begin
                            state_d = S_FAILED;
                        end else begin
                            state_d   = S_RESET_PLL;
                            retry_inc = 1'b1;
                        end
                    end
                end
                S_STABILISE: begin
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d   = S_RUN;
                        retry_clr = 1'b1;
                    end
                end
                // in RUN the timer holds the run of consecutive unlocked cycles
                S_RUN: begin
                    if (!locked_s && (timer_q == GLITCH_LAST)) begin
                        state_d  = S_RESET_PLL;
                        lost_inc = 1'b1;
                    end
                end
                S_FAILED: state_d = S_FAILED;
                default:  state_d = S_RESET_PLL;
            endcase
        end

        // every state leaves at its limit, so the timer can never wrap
        if (restart || (state_d != state_q))            timer_d = '0;
        else if (state_q == S_FAILED)                   timer_d = '0;
        else if ((state_q == S_RUN) && locked_s)        timer_d = '0;
        else                                            timer_d = timer_q + 1'b1;
    end

    always_comb begin
        pll_rst_d     = 1'b1;
        sys_reset_n_d = 1'b0;
        ready_d       = 1'b0;
        failed_d      = 1'b0;
        case (state_d)
            S_WAIT_LOCK, S_STABILISE: pll_rst_d = 1'b0;
            S_RUN: begin
                pll_rst_d     = 1'b0;
                sys_reset_n_d = 1'b1;
                ready_d       = 1'b1;
            end
            S_FAILED: failed_d = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed timing scenarios plus a randomized LOCK/restart
// run checked cycle by cycle against a behavioural model of the sequencing rules.
module tb_pll_lock_supervisor;

    localparam int RST = 4, TO = 20, STABLE = 8, GLITCH = 3, MAXR = 2, CW = 2;
    localparam int LOST_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          restart = 1'b0;
    logic          pll_rst, sys_reset_n, ready, failed;
    logic [2:0]    state;
    logic [CW-1:0] retry_count, lost_count;
    int            n_checks = 0;
    int            n_fail = 0;

    pll_lock_supervisor #(
        .RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STABLE),
        .GLITCH_CYCLES(GLITCH), .MAX_RETRIES(MAXR), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .restart(restart),
        .pll_rst(pll_rst), .sys_reset_n(sys_reset_n), .ready(ready), .failed(failed),
        .state(state), .retry_count(retry_count), .lost_count(lost_count)
    );

    always #5 clk = ~clk;

    // Reference model: phase number, cycles spent in the phase (consecutive unlocked
    // cycles while running), attempt and loss tallies, and a two-deep LOCK history.
    int   m_state, m_cnt, m_retry, m_lost;
    int   mn_state, mn_cnt, mn_retry, mn_lost;
    logic m_s0, m_ls;

    always_comb begin
        mn_state = m_state;
        mn_cnt   = m_cnt + 1;
        mn_retry = m_retry;
        mn_lost  = m_lost;
        if (restart) begin
            mn_state = 0;
            mn_retry = 0;
        end else if (m_state == 0) begin
            if (mn_cnt >= RST) mn_state = 1;
        end else if (m_state == 1) begin
            if (m_ls) mn_state = 2;
            else if (mn_cnt >= TO) begin
                if (m_retry >= MAXR) mn_state = 4;
                else begin
                    mn_state = 0;
                    mn_retry = m_retry + 1;
                end
            end
        end else if (m_state == 2) begin
            if (!m_ls) mn_state = 1;
            else if (mn_cnt >= STABLE) begin
                mn_state = 3;
                mn_retry = 0;
            end
        end else if (m_state == 3) begin
            if (m_ls) mn_cnt = 0;
            else if (mn_cnt >= GLITCH) begin
                mn_state = 0;
                if (m_lost < LOST_MAX) mn_lost = m_lost + 1;
            end
        end else begin
            mn_cnt = 0;
        end
        if (mn_state != m_state || restart) mn_cnt = 0;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state <= 0; m_cnt <= 0; m_retry <= 0; m_lost <= 0;
            m_s0 <= 1'b0; m_ls <= 1'b0;
        end else begin
            m_state <= mn_state; m_cnt <= mn_cnt; m_retry <= mn_retry; m_lost <= mn_lost;
            m_s0 <= pll_locked; m_ls <= m_s0;
        end
    end

    function automatic logic [10:0] dut_vec();
        return {state, pll_rst, sys_reset_n, ready, failed, retry_count, lost_count};
    endfunction

    function automatic logic [10:0] mdl_vec();
        logic [2:0]    s;
        logic [CW-1:0] r, l;
        s = 3'(m_state);
        r = CW'(m_retry);
        l = CW'(m_lost);
        return {s, (m_state == 0) || (m_state == 4), m_state == 3, m_state == 3, m_state == 4, r, l};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== 3'd0) begin
            n_fail++; $display("FAIL reset_state got=%0d exp=0", state);
        end
        n_checks++;
        if ({pll_rst, sys_reset_n, ready, failed} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_outputs got=%b exp=1000", {pll_rst, sys_reset_n, ready, failed});
        end
        n_checks++;
        if ({retry_count, lost_count} !== '0) begin
            n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", retry_count, lost_count);
        end
    endtask

    task automatic test_normal_lock();
        int n;
        pll_locked = 1'b0; restart = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (pll_rst && n < 50);
        n_checks++;
        if (n != RST) begin n_fail++; $display("FAIL pll_rst_width got=%0d exp=%0d", n, RST); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== 3'd1) begin n_fail++; $display("FAIL wait_lock_state got=%0d exp=1", state); end
        pll_locked = 1'b1;
        // two synchroniser flops, then the deciding edge
        n = 0;
        do begin @(negedge clk); n++; end while (state != 3'd2 && n < 20);
        n_checks++;
        if (n != 3) begin n_fail++; $display("FAIL lock_to_stabilise got=%0d exp=3", n); end
        n = 0;
        do begin @(negedge clk); n++; end while (state == 3'd2 && n < 20);
        n_checks++;
        if (n != STABLE || state !== 3'd3) begin
            n_fail++; $display("FAIL stabilise_len got=%0d state=%0d exp=%0d state=3", n, state, STABLE);
        end
        n_checks++;
        if ({sys_reset_n, ready, pll_rst, failed, retry_count} !== {4'b1100, 2'd0}) begin
            n_fail++; $display("FAIL run_outputs got=%b%b%b%b r=%0d exp=1100 r=0", sys_reset_n, ready, pll_rst, failed, retry_count);
        end
    endtask

    task automatic test_glitch();
        int n;
        pll_locked = 1'b0; repeat (2) @(negedge clk); pll_locked = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (state !== 3'd3 || lost_count !== 2'd0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL short_glitch state=%0d lost=%0d ready=%b exp 3/0/1", state, lost_count, ready);
        end
        pll_locked = 1'b0; repeat (3) @(negedge clk); pll_locked = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (state == 3'd3 && n < 10);
        n_checks++;
        if (n != 2) begin n_fail++; $display("FAIL glitch_latency got=%0d exp=2", n); end
        n_checks++;
        if (state !== 3'd0 || sys_reset_n !== 1'b0 || pll_rst !== 1'b1 || lost_count !== 2'd1) begin
            n_fail++; $display("FAIL lock_loss state=%0d srn=%b rst=%b lost=%0d exp 0/0/1/1", state, sys_reset_n, pll_rst, lost_count);
        end
    endtask

    task automatic test_priority_and_reset();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (state != 3'd3 && n < 40);
        n_checks++;
        if (state !== 3'd3) begin n_fail++; $display("FAIL relock_run got=%0d exp=3", state); end
        // restart coincides with the edge where the glitch count reaches its limit
        pll_locked = 1'b0; repeat (4) @(negedge clk);
        restart = 1'b1; @(negedge clk); restart = 1'b0; pll_locked = 1'b1;
        n_checks++;
        if (state !== 3'd0 || lost_count !== 2'd1 || retry_count !== 2'd0) begin
            n_fail++; $display("FAIL restart_priority state=%0d lost=%0d retry=%0d exp 0/1/0", state, lost_count, retry_count);
        end
        n = 0;
        do begin @(negedge clk); n++; end while (state != 3'd3 && n < 40);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({state, pll_rst, sys_reset_n, ready, failed, retry_count, lost_count} !== {3'd0, 4'b1000, 4'd0}) begin
            n_fail++; $display("FAIL async_reset state=%0d rst=%b srn=%b ready=%b lost=%0d exp 0/1/0/0/0", state, pll_rst, sys_reset_n, ready, lost_count);
        end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_stabilise_abort();
        int n;
        reset_n = 1'b0; pll_locked = 1'b0; @(negedge clk); reset_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (retry_count != 2'd1 && n < 100);
        n_checks++;
        if (n != RST + TO) begin n_fail++; $display("FAIL first_timeout got=%0d exp=%0d", n, RST + TO); end
        pll_locked = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (state != 3'd2 && n < 60);
        repeat (2) @(negedge clk); pll_locked = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (state == 3'd2 && n < 20);
        n_checks++;
        if (n != 3 || state !== 3'd1 || retry_count !== 2'd1) begin
            n_fail++; $display("FAIL stabilise_abort n=%0d state=%0d retry=%0d exp 3/1/1", n, state, retry_count);
        end
        @(negedge clk); pll_locked = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (state != 3'd2 && n < 30);
        n = 0;
        do begin @(negedge clk); n++; end while (state == 3'd2 && n < 20);
        n_checks++;
        if (n != STABLE || state !== 3'd3 || retry_count !== 2'd0) begin
            n_fail++; $display("FAIL relock_window n=%0d state=%0d retry=%0d exp %0d/3/0", n, state, retry_count, STABLE);
        end
    endtask

    task automatic test_timeout_fail();
        int         n;
        int         seen[$];
        logic [2:0] prev;
        reset_n = 1'b0; pll_locked = 1'b0; restart = 1'b0; @(negedge clk); reset_n = 1'b1;
        prev = 3'd0;
        n = 0;
        while (state != 3'd4 && n < 200) begin
            @(negedge clk); n++;
            if (state == 3'd1 && prev != 3'd1) seen.push_back(int'(retry_count));
            prev = state;
        end
        n_checks++;
        if (n != (MAXR + 1) * (RST + TO)) begin
            n_fail++; $display("FAIL fail_latency got=%0d exp=%0d", n, (MAXR + 1) * (RST + TO));
        end
        n_checks++;
        if (seen.size() != 3 || seen[0] != 0 || seen[1] != 1 || seen[2] != 2) begin
            n_fail++; $display("FAIL retry_sequence got=%p exp='{0,1,2}", seen);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (state !== 3'd4 || failed !== 1'b1 || pll_rst !== 1'b1 || sys_reset_n !== 1'b0) begin
            n_fail++; $display("FAIL failed_hold state=%0d failed=%b rst=%b srn=%b exp 4/1/1/0", state, failed, pll_rst, sys_reset_n);
        end
        restart = 1'b1; @(negedge clk); restart = 1'b0;
        n_checks++;
        if (state !== 3'd0 || retry_count !== 2'd0 || failed !== 1'b0 || pll_rst !== 1'b1) begin
            n_fail++; $display("FAIL restart_from_failed state=%0d retry=%0d failed=%b exp 0/0/0", state, retry_count, failed);
        end
    endtask

    task automatic test_saturation();
        int            n;
        logic [CW-1:0] exp_lost;
        reset_n = 1'b0; @(negedge clk); pll_locked = 1'b1; reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (state != 3'd3 && n < 60);
            pll_locked = 1'b0; repeat (4) @(negedge clk); pll_locked = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (state == 3'd3 && n < 10);
            exp_lost = CW'((k < LOST_MAX) ? k : LOST_MAX);
            n_checks++;
            if (lost_count !== exp_lost) begin
                n_fail++; $display("FAIL lost_saturation loss=%0d got=%0d exp=%0d", k, lost_count, exp_lost);
            end
        end
    endtask

    task automatic test_random();
        int left, r;
        reset_n = 1'b0; restart = 1'b0; pll_locked = 1'b0; @(negedge clk); reset_n = 1'b1;
        left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL random_vs_model cycle=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
            end
            if (left == 0) begin
                r = $urandom_range(0, 99);
                if (r < 60)      begin pll_locked = 1'b1; left = $urandom_range(5, 60); end
                else if (r < 90) begin pll_locked = 1'b0; left = $urandom_range(1, 5); end
                else             begin pll_locked = 1'b0; left = $urandom_range(20, 90); end
            end
            left--;
            restart = ($urandom_range(0, 199) == 0);
        end
        restart = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_lock();
        test_glitch();
        test_priority_and_reset();
        test_stabilise_abort();
        test_timeout_fail();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t limit reached", $time);
        $fatal(1, "watchdog");
    end

endmodule
